multi_debnc: RTL
================

MULTI_DEBNC -- requirements
Module: multi_debnc

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-high; ports are named clk and rst.
REQ-002 Parameter N_CH, default 4: number of independent switch channels; SHALL be 1..32.
REQ-003 Parameter DB_CYCLES, default 1000000: stable-time window in clk cycles; SHALL be >= 2, rejected at elaboration otherwise.
REQ-004 Parameter CNT_W, default $clog2(DB_CYCLES): per-channel counter width.
REQ-005 clk  input  1  system clock, rising-edge active.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 sw  input  N_CH  raw asynchronous switch levels.
REQ-008 mode  input  N_CH  per-channel mode: 0 = delayed debounce, 1 = early debounce.
REQ-009 db  output  N_CH  debounced levels.
REQ-010 rise_tick  output  N_CH  one-cycle pulse on db 0->1 (present only with DEBNC_EDGE_EN).
REQ-011 fall_tick  output  N_CH  one-cycle pulse on db 1->0 (present only with DEBNC_EDGE_EN).

Function
REQ-012 Each sw bit SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the second flop (s).
REQ-013 Each channel SHALL run an FSM with states ZERO, WAIT1, ONE, WAIT0, plus a CNT_W-bit counter and a latched mode bit.
REQ-014 ZERO with s=1 -> WAIT1, counter cleared, mode latched; ONE with s=0 -> WAIT0, counter cleared, mode latched.
REQ-015 Delayed mode, WAIT1: s=0 -> ZERO; s=1 and cnt=DB_CYCLES-1 -> ONE; otherwise cnt+1. WAIT0 is symmetric (s=1 -> ONE; expiry -> ZERO).
REQ-016 Early mode, WAIT1/WAIT0: s ignored; cnt+1 each cycle; cnt=DB_CYCLES-1 -> ONE/ZERO respectively.
REQ-017 db SHALL be registered: 1 in ONE; 1 in WAIT0 if latched mode=0; 1 in WAIT1 if latched mode=1; else 0.
REQ-018 Latency, counted from the first edge sampling a new sw level: delayed db change at edge DB_CYCLES+3 if s stays stable; early db change at edge 3.
REQ-019 A pulse shorter than the window SHALL NOT change db in delayed mode; in early mode, input changes during a window SHALL be ignored, and the new s SHALL be evaluated from ONE/ZERO on the cycle after expiry.
REQ-020 mode changes SHALL take effect only at the next ZERO/ONE -> WAIT transition; the latched mode SHALL govern an in-progress window.
REQ-021 The counter SHALL never wrap; it is cleared on every WAIT entry.
REQ-022 Channels SHALL be fully independent; simultaneous events on all channels SHALL be handled in the same cycle.

Reset
REQ-023 rst=1 SHALL, without a clock edge, force synchronizers to 0, all FSMs to ZERO, counters and latched modes to 0, and db, rise_tick and fall_tick to 0.
REQ-024 After rst deassertion with sw held at 1, db SHALL rise per REQ-018 as for a fresh edge; no tick SHALL be emitted at reset release.

Configuration
REQ-025 Macro DEBNC_EDGE_EN defined: rise_tick/fall_tick exist and pulse high for exactly one cycle, in the same cycle db takes its new value.
REQ-026 DEBNC_EDGE_EN undefined: the tick ports and their logic SHALL be absent; db behaviour is unchanged.

Structure
REQ-027 Package debnc_pkg SHALL hold the state enum (ZERO, WAIT1, ONE, WAIT0), the mode constants DEBNC_DELAYED=0 and DEBNC_EARLY=1, and the DB_CYCLES legality check function.
REQ-028 A sub-module debnc_chan (synchronizer, FSM, counter, tick logic for one channel) SHALL be instantiated N_CH times in a generate loop.

Verification (N_CH=2, DB_CYCLES=8, clk period 20 ns)
REQ-029 rst=1 with sw=2'b11 -> db=0 and ticks=0; release rst with sw held, mode=0 -> db=2'b11 at edge 11 after release, with one rise_tick per channel.
REQ-030 sw[0] toggles every cycle for 5 cycles, then holds 1, mode[0]=0 -> db[0] stays 0 throughout, rises 11 edges after the last 0->1, single rise_tick[0].
REQ-031 mode[1]=1, sw[1] 0->1, then a 2-cycle 0 glitch at cycle 4 -> db[1]=1 at edge 3, held through the window; fall begins only if s=0 after expiry.
REQ-032 db[0]=1 (delayed), sw[0] low for 4 cycles -> db[0] stays 1, no fall_tick[0].
REQ-033 mode[0] flipped 0->1 mid-WAIT1 -> window completes under delayed rules; early rules apply only at the next transition.
REQ-034 rst asserted mid-WAIT0 between clock edges -> db and the counter clear immediately; no fall_tick emitted.

Source files
------------

// File: rtl/debnc_pkg.sv
// Shared types and constants for the multi-channel switch debouncer.
package debnc_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } debnc_state_t;

    localparam logic DEBNC_DELAYED = 1'b0;
    localparam logic DEBNC_EARLY   = 1'b1;

    function automatic bit debnc_cycles_ok(input int unsigned cycles);
        return cycles >= 2;
    endfunction

endpackage

// File: rtl/debnc_chan.sv
// One debounce channel: 2-flop synchronizer, ZERO/WAIT1/ONE/WAIT0 FSM, window counter.
// Edge ticks are built only when DEBNC_EDGE_EN is defined.
module debnc_chan
    import debnc_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    input  logic mode,
`ifdef DEBNC_EDGE_EN
    output logic rise_tick,
    output logic fall_tick,
`endif
    output logic db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             s_p1;
    debnc_state_t     state_p2, state_nxt;
    logic [CNT_W-1:0] cnt_p2, cnt_nxt;
    logic             mode_p2, mode_nxt;
    logic             db_p2, db_nxt;

    // stage 0/1: synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            s_p1    <= 1'b0;
        end else begin
            sync_p0 <= sw;
            s_p1    <= sync_p0;
        end
    end

    // stage 2: FSM, window counter and registered db
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p2 <= ZERO;
            cnt_p2   <= '0;
            mode_p2  <= DEBNC_DELAYED;
            db_p2    <= 1'b0;
        end else begin
            state_p2 <= state_nxt;
            cnt_p2   <= cnt_nxt;
            mode_p2  <= mode_nxt;
            db_p2    <= db_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p2;
        cnt_nxt   = cnt_p2;
        mode_nxt  = mode_p2;
        case (state_p2)
            ZERO: begin
                if (s_p1) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = '0;
                    mode_nxt  = mode;
                end
            end
            ONE: begin
                if (!s_p1) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = '0;
                    mode_nxt  = mode;
                end
            end
            WAIT1: begin
                if (mode_p2 == DEBNC_DELAYED && !s_p1)
                    state_nxt = ZERO;
                else if (cnt_p2 == CNT_LAST)
                    state_nxt = ONE;
                else
                    cnt_nxt = cnt_p2 + CNT_W'(1);
            end
            WAIT0: begin
                if (mode_p2 == DEBNC_DELAYED && s_p1)
                    state_nxt = ONE;
                else if (cnt_p2 == CNT_LAST)
                    state_nxt = ZERO;
                else
                    cnt_nxt = cnt_p2 + CNT_W'(1);
            end
        endcase
        // db is decoded from the next state so early mode flips on the WAIT entry edge
        db_nxt = (state_nxt == ONE) ||
                 (state_nxt == WAIT0 && mode_nxt == DEBNC_DELAYED) ||
                 (state_nxt == WAIT1 && mode_nxt == DEBNC_EARLY);
    end

    assign db = db_p2;

`ifdef DEBNC_EDGE_EN
    logic rise_p2, fall_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_p2 <= 1'b0;
            fall_p2 <= 1'b0;
        end else begin
            rise_p2 <= db_nxt & ~db_p2;
            fall_p2 <= ~db_nxt & db_p2;
        end
    end

    assign rise_tick = rise_p2;
    assign fall_tick = fall_p2;
`endif

endmodule

// File: rtl/multi_debnc.sv
// N_CH independent switch debouncers with per-channel delayed/early mode.
// Optional rise_tick/fall_tick outputs when DEBNC_EDGE_EN is defined.
module multi_debnc
    import debnc_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw,
    input  logic [N_CH-1:0] mode,
`ifdef DEBNC_EDGE_EN
    output logic [N_CH-1:0] rise_tick,
    output logic [N_CH-1:0] fall_tick,
`endif
    output logic [N_CH-1:0] db
);

    generate
        if (!debnc_cycles_ok(DB_CYCLES)) begin : g_bad_cycles
            $error("multi_debnc: DB_CYCLES must be >= 2");
        end
        if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
            $error("multi_debnc: N_CH must be in 1..32");
        end
    endgenerate

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debnc_chan #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .sw        (sw[i]),
            .mode      (mode[i]),
`ifdef DEBNC_EDGE_EN
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i]),
`endif
            .db        (db[i])
        );
    end

endmodule
